// File: rtl/flag_period_monitor_pkg.sv
// Shared types for the flag period monitor.
// Holds monitor states and lock counter width.
package flag_period_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        LOCK = 2'd2
    } mon_state_t;

    localparam int GOOD_W = 4;

endpackage

// File: rtl/flag_gap_counter.sv
// Saturating sys_clk counter of cycles since the last flag.
// Cleared in IDLE so the first flag starts a fresh reference.
module flag_gap_counter
    import flag_period_monitor_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clk_flag,
    input  logic             active,
    output logic [CNT_W-1:0] gap,
    output logic             sat_next
);

    localparam logic [CNT_W-1:0] GAP_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_MAX = '1;
    localparam logic [CNT_W-1:0] GAP_PRE = GAP_MAX - GAP_ONE;

    assign sat_next = (gap == GAP_PRE);

    // Restart at 1 on a flag, hold 0 while idle, else count to saturation
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gap <= '0;
        end else if (clk_flag) begin
            gap <= GAP_ONE;
        end else if (!active) begin
            gap <= '0;
        end else if (gap != GAP_MAX) begin
            gap <= gap + GAP_ONE;
        end
    end

endmodule

// File: rtl/flag_period_monitor.sv
// Measures clk_flag period, tracks lock to the expected ratio,
// and pulses err on lost lock and timeout on a missing flag.
module flag_period_monitor
    import flag_period_monitor_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 5,
    parameter int LOCK_CNT   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clk_flag,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]  EXP_P  = CNT_W'(EXP_PERIOD);
    localparam logic [GOOD_W-1:0] LOCK_N = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] G_ONE  = GOOD_W'(1);

    mon_state_t        state;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_inc;
    logic [CNT_W-1:0]  gap;
    logic              sat_next;
    logic              active;
    logic              match;

    assign active   = (state != IDLE);
    assign match    = (gap == EXP_P);
    assign good_inc = good + G_ONE;

    flag_gap_counter #(
        .CNT_W    (CNT_W)
    ) u_gap (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clk_flag (clk_flag),
        .active   (active),
        .gap      (gap),
        .sat_next (sat_next)
    );

    // FSM, good-period counter and registered status pulses
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            good       <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clk_flag) begin
                        state <= MEAS;
                    end
                end
                MEAS: begin
                    if (clk_flag) begin
                        period     <= gap;
                        period_vld <= 1'b1;
                        if (match) begin
                            good <= good_inc;
                            if (good_inc == LOCK_N) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end else if (sat_next) begin
                        timeout <= 1'b1;
                        good    <= '0;
                        locked  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                LOCK: begin
                    if (clk_flag) begin
                        period     <= gap;
                        period_vld <= 1'b1;
                        if (!match) begin
                            err    <= 1'b1;
                            locked <= 1'b0;
                            good   <= '0;
                            state  <= MEAS;
                        end
                    end else if (sat_next) begin
                        timeout <= 1'b1;
                        good    <= '0;
                        locked  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    good   <= '0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flag_period_monitor.sv
// Directed bench for flag_period_monitor (defaults 8/5/4).
// Hand-computed expectations checked with immediate assertions.
module tb_flag_period_monitor;

    logic       sys_clk;
    logic       sys_rst;
    logic       clk_flag;
    logic [7:0] period;
    logic       period_vld;
    logic       locked;
    logic       err;
    logic       timeout;

    int tests;
    int fails;

    flag_period_monitor #(
        .CNT_W      (8),
        .EXP_PERIOD (5),
        .LOCK_CNT   (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .clk_flag   (clk_flag),
        .period     (period),
        .period_vld (period_vld),
        .locked     (locked),
        .err        (err),
        .timeout    (timeout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drive flag, let one edge sample it, look 1 time unit later
    task automatic step(input logic f);
        clk_flag = f;
        @(posedge sys_clk);
        #1;
    endtask

    // n-cycle period ending on a flag edge; checks pulses cleared early
    task automatic per(input int n, input string tag);
        step(1'b0);
        chk({tag, "_clr"}, {29'd0, period_vld, err, timeout}, 32'd0);
        for (int i = 0; i < n - 2; i++) step(1'b0);
        step(1'b1);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        sys_rst  = 1'b1;
        clk_flag = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_period", {24'd0, period}, 32'd0);
        chk("rst_flags", {28'd0, period_vld, locked, err, timeout}, 32'd0);
        sys_rst = 1'b0;
        step(1'b0);
        chk("rel_flags", {28'd0, period_vld, locked, err, timeout}, 32'd0);

        // scenario 1: first flag gives no measurement, lock at 5th flag
        step(1'b1);
        chk("s1_f1_vld", {31'd0, period_vld}, 32'd0);
        per(5, "s1_f2");
        chk("s1_f2_vld", {31'd0, period_vld}, 32'd1);
        chk("s1_f2_per", {24'd0, period}, 32'd5);
        per(5, "s1_f3");
        per(5, "s1_f4");
        chk("s1_f4_lck", {31'd0, locked}, 32'd0);
        per(5, "s1_f5");
        chk("s1_f5_lck", {31'd0, locked}, 32'd1);
        chk("s1_f5_err", {31'd0, err}, 32'd0);

        // scenario 2: one 7-cycle gap breaks lock, four 5s relock
        per(7, "s2_g7");
        chk("s2_g7_per", {24'd0, period}, 32'd7);
        chk("s2_g7_err", {30'd0, err, locked}, 32'd2);
        per(5, "s2_r1");
        per(5, "s2_r2");
        per(5, "s2_r3");
        chk("s2_r3_lck", {31'd0, locked}, 32'd0);
        per(5, "s2_r4");
        chk("s2_r4_lck", {30'd0, locked, err}, 32'd2);

        // scenario 3: flag lost, timeout as gap saturates at 255
        for (int i = 0; i < 253; i++) step(1'b0);
        chk("s3_pre_to", {30'd0, timeout, locked}, 32'd1);
        step(1'b0);
        chk("s3_to", {29'd0, timeout, locked, err}, 32'd4);
        step(1'b0);
        chk("s3_to_clr", {31'd0, timeout}, 32'd0);
        step(1'b0);
        chk("s3_idle", {30'd0, timeout, locked}, 32'd0);
        step(1'b1);
        chk("s3_f1_vld", {31'd0, period_vld}, 32'd0);
        per(5, "s3_f2");
        chk("s3_f2_vld", {31'd0, period_vld}, 32'd1);
        chk("s3_f2_per", {24'd0, period}, 32'd5);

        // scenario 4: alternating 6/5 never locks, no err
        per(6, "s4_a");
        chk("s4_a_per", {24'd0, period}, 32'd6);
        per(5, "s4_b");
        per(6, "s4_c");
        per(5, "s4_d");
        per(6, "s4_e");
        chk("s4_e_st", {30'd0, locked, err}, 32'd0);
        per(5, "s4_l1");
        per(5, "s4_l2");
        per(5, "s4_l3");
        per(5, "s4_l4");
        chk("s4_relock", {31'd0, locked}, 32'd1);

        // scenario 5: flag stuck high right after a lock flag
        step(1'b1);
        chk("s5_first", {21'd0, period, period_vld, locked, err},
            {21'd0, 8'd1, 1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 9; i++) begin
            step(1'b1);
            chk("s5_held", {21'd0, period, period_vld, locked, err},
                {21'd0, 8'd1, 1'b1, 1'b0, 1'b0});
        end
        per(5, "s5_r1");
        chk("s5_r1_per", {24'd0, period}, 32'd5);
        per(5, "s5_r2");
        per(5, "s5_r3");
        per(5, "s5_r4");
        chk("s5_relock", {31'd0, locked}, 32'd1);

        // scenario 6: async reset mid-period while locked
        step(1'b0);
        step(1'b0);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("s6_async",
            {20'd0, period, period_vld, locked, err, timeout}, 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        step(1'b0);
        chk("s6_rel", {28'd0, period_vld, locked, err, timeout}, 32'd0);
        step(1'b1);
        chk("s6_f1_vld", {31'd0, period_vld}, 32'd0);
        per(5, "s6_f2");
        chk("s6_f2_per", {24'd0, period}, 32'd5);
        per(5, "s6_f3");
        per(5, "s6_f4");
        chk("s6_f4_lck", {31'd0, locked}, 32'd0);
        per(5, "s6_f5");
        chk("s6_f5_lck", {31'd0, locked}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
